debug_run_controller: RTL and testbench

// Sequences the MIPS pipeline on behalf of the debug unit. It accepts decoded UART commands
// (load, continuous run, single step, dump) and produces the pipeline enable, flush and load

---
 rtl/debug_run_controller_pkg.sv | 22 ++
 rtl/debug_run_controller_sat_counter.sv | 20 ++
 rtl/debug_run_controller.sv | 149 ++++++++++++++
 tb/tb_debug_run_controller.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_run_controller_pkg.sv
// Shared command codes, FSM state encoding and parameter defaults for the debug run controller.
package debug_run_controller_pkg;

  localparam int CMD_WIDTH_DEF      = 8;
  localparam int CYCLE_CNT_BITS_DEF = 32;
  localparam int MAX_RUN_CYCLES_DEF = 4096;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN  = 8'h43;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_DUMP = 8'h44;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_STEP,
    ST_DUMP,
    ST_HALTED
  } state_t;

endpackage

// File: rtl/debug_run_controller_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment); one-cycle update latency.
module debug_run_controller_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/debug_run_controller.sv
// Sequences pipeline load/run/step/dump for the debug unit; all outputs registered except o_cmd_ready.
// Commands take effect one clock after acceptance; commands offered while busy are dropped with o_cmd_err.
module debug_run_controller
  import debug_run_controller_pkg::*;
#(
  parameter int CMD_WIDTH      = CMD_WIDTH_DEF,
  parameter int CYCLE_CNT_BITS = CYCLE_CNT_BITS_DEF,
  parameter int MAX_RUN_CYCLES = MAX_RUN_CYCLES_DEF
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_cmd_valid,
  input  logic [CMD_WIDTH-1:0]      i_cmd,
  input  logic                      i_load_done,
  input  logic                      i_program_finished,
  input  logic                      i_dump_done,
  output logic                      o_cmd_ready,
  output logic                      o_cmd_err,
  output logic                      o_load_mode,
  output logic                      o_pipeline_flush,
  output logic                      o_pipeline_enable,
  output logic                      o_dump_req,
  output logic                      o_timeout,
  output logic [CYCLE_CNT_BITS-1:0] o_cycle_count
);

  localparam int RUN_W = $clog2(MAX_RUN_CYCLES + 1);

  state_t state, state_nx;
  logic cmd_err_nx, load_mode_nx, flush_nx, enable_nx, dump_req_nx, timeout_nx;
  logic cnt_clear, run_clear;
  logic [RUN_W-1:0] run_cnt;
  logic cmd_load, cmd_run, cmd_step, cmd_dump, cmd_known;

  assign o_cmd_ready = (state == ST_IDLE) || (state == ST_HALTED);

  assign cmd_load  = (i_cmd == CMD_WIDTH'(CMD_LOAD));
  assign cmd_run   = (i_cmd == CMD_WIDTH'(CMD_RUN));
  assign cmd_step  = (i_cmd == CMD_WIDTH'(CMD_STEP));
  assign cmd_dump  = (i_cmd == CMD_WIDTH'(CMD_DUMP));
  assign cmd_known = cmd_load | cmd_run | cmd_step | cmd_dump;

  always_comb begin
    state_nx     = state;
    cmd_err_nx   = i_cmd_valid && (!o_cmd_ready || !cmd_known);
    load_mode_nx = o_load_mode;
    flush_nx     = 1'b0;
    enable_nx    = 1'b0;
    dump_req_nx  = o_dump_req;
    timeout_nx   = o_timeout;
    cnt_clear    = 1'b0;
    unique case (state)
      ST_IDLE, ST_HALTED: begin
        if (i_cmd_valid) begin
          if (cmd_load) begin
            state_nx     = ST_LOAD;
            flush_nx     = 1'b1;
            load_mode_nx = 1'b1;
            timeout_nx   = 1'b0;
            cnt_clear    = 1'b1;
          end else if (cmd_dump) begin
            state_nx    = ST_DUMP;
            dump_req_nx = 1'b1;
          end else if ((cmd_run || cmd_step) && (state == ST_HALTED)) begin
            cmd_err_nx = 1'b1;
          end else if (cmd_run || cmd_step) begin
            // A program already at HALT gets no enable cycle at all.
            if (i_program_finished) begin
              state_nx    = ST_DUMP;
              dump_req_nx = 1'b1;
            end else begin
              state_nx  = cmd_run ? ST_RUN : ST_STEP;
              enable_nx = 1'b1;
            end
          end
        end
      end
      ST_LOAD: begin
        if (i_load_done) begin
          state_nx     = ST_IDLE;
          load_mode_nx = 1'b0;
        end
      end
      ST_RUN: begin
        // run_cnt already includes the enable cycle in progress.
        if (i_program_finished) begin
          state_nx    = ST_DUMP;
          dump_req_nx = 1'b1;
        end else if (run_cnt >= RUN_W'(MAX_RUN_CYCLES)) begin
          state_nx    = ST_DUMP;
          dump_req_nx = 1'b1;
          timeout_nx  = 1'b1;
        end else begin
          enable_nx = 1'b1;
        end
      end
      ST_STEP: begin
        state_nx    = ST_DUMP;
        dump_req_nx = 1'b1;
      end
      ST_DUMP: begin
        if (i_dump_done) begin
          state_nx    = i_program_finished ? ST_HALTED : ST_IDLE;
          dump_req_nx = 1'b0;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign run_clear = (state_nx != ST_RUN);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state             <= ST_IDLE;
      o_cmd_err         <= 1'b0;
      o_load_mode       <= 1'b0;
      o_pipeline_flush  <= 1'b0;
      o_pipeline_enable <= 1'b0;
      o_dump_req        <= 1'b0;
      o_timeout         <= 1'b0;
    end else begin
      state             <= state_nx;
      o_cmd_err         <= cmd_err_nx;
      o_load_mode       <= load_mode_nx;
      o_pipeline_flush  <= flush_nx;
      o_pipeline_enable <= enable_nx;
      o_dump_req        <= dump_req_nx;
      o_timeout         <= timeout_nx;
    end
  end

  debug_run_controller_sat_counter #(.WIDTH(CYCLE_CNT_BITS)) u_cycle_cnt (
    .clk   (i_clk),
    .reset (i_reset),
    .clear (cnt_clear),
    .inc   (enable_nx),
    .count (o_cycle_count)
  );

  debug_run_controller_sat_counter #(.WIDTH(RUN_W)) u_watchdog (
    .clk   (i_clk),
    .reset (i_reset),
    .clear (run_clear),
    .inc   (enable_nx),
    .count (run_cnt)
  );

endmodule

// File: tb/tb_debug_run_controller.sv
// Randomized scenario bench: expectations come from transaction-level arithmetic over observed pulse counts.
module tb_debug_run_controller;

  localparam int MAXR = 24;
  localparam logic [7:0] C_LOAD = 8'h4C;
  localparam logic [7:0] C_RUN  = 8'h43;
  localparam logic [7:0] C_STEP = 8'h53;
  localparam logic [7:0] C_DUMP = 8'h44;

  logic        i_clk = 1'b0;
  logic        i_reset, i_cmd_valid, i_load_done, i_program_finished, i_dump_done;
  logic [7:0]  i_cmd;
  logic        o_cmd_ready, o_cmd_err, o_load_mode, o_pipeline_flush;
  logic        o_pipeline_enable, o_dump_req, o_timeout;
  logic [31:0] o_cycle_count;

  int total = 0;
  int bad   = 0;
  int en_cyc = 0, en_run = 0, last_run = 0, fl_cyc = 0, lm_cyc = 0, err_cyc = 0;
  int b_en, b_fl, b_lm, b_err;
  longint exp_count;

  debug_run_controller #(
    .CMD_WIDTH      (8),
    .CYCLE_CNT_BITS (32),
    .MAX_RUN_CYCLES (MAXR)
  ) dut (
    .i_clk              (i_clk),
    .i_reset            (i_reset),
    .i_cmd_valid        (i_cmd_valid),
    .i_cmd              (i_cmd),
    .i_load_done        (i_load_done),
    .i_program_finished (i_program_finished),
    .i_dump_done        (i_dump_done),
    .o_cmd_ready        (o_cmd_ready),
    .o_cmd_err          (o_cmd_err),
    .o_load_mode        (o_load_mode),
    .o_pipeline_flush   (o_pipeline_flush),
    .o_pipeline_enable  (o_pipeline_enable),
    .o_dump_req         (o_dump_req),
    .o_timeout          (o_timeout),
    .o_cycle_count      (o_cycle_count)
  );

  always #5 i_clk = ~i_clk;

  // Pulse/level accounting on the falling edge, away from register updates.
  always @(negedge i_clk) begin
    if (o_pipeline_enable) begin
      en_cyc <= en_cyc + 1;
      en_run <= en_run + 1;
    end else begin
      if (en_run != 0) last_run <= en_run;
      en_run <= 0;
    end
    if (o_pipeline_flush) fl_cyc  <= fl_cyc + 1;
    if (o_load_mode)      lm_cyc  <= lm_cyc + 1;
    if (o_cmd_err)        err_cyc <= err_cyc + 1;
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic mark();
    b_en  = en_cyc;
    b_fl  = fl_cyc;
    b_lm  = lm_cyc;
    b_err = err_cyc;
  endtask

  task automatic send_cmd(input logic [7:0] code);
    i_cmd_valid = 1'b1;
    i_cmd       = code;
    tick();
    i_cmd_valid = 1'b0;
    i_cmd       = 8'($urandom);
  endtask

  task automatic wait_dump(input string tag);
    int n = 0;
    while (!o_dump_req && n < 300) begin
      tick();
      n++;
    end
    chk(tag, o_dump_req, 1);
  endtask

  task automatic finish_dump(input int delay);
    repeat (delay - 1) tick();
    chk("dump_hold", o_dump_req, 1);
    i_dump_done = 1'b1;
    tick();
    i_dump_done = 1'b0;
    chk("dump_drop", o_dump_req, 0);
  endtask

  task automatic do_load(input int n);
    mark();
    send_cmd(C_LOAD);
    repeat (n - 1) tick();
    i_load_done = 1'b1;
    tick();
    i_load_done = 1'b0;
    tick();
    exp_count = 0;
    chk("load_flush_pulses", fl_cyc - b_fl, 1);
    chk("load_mode_cycles", lm_cyc - b_lm, n);
    chk("load_mode_off", o_load_mode, 0);
    chk("load_count", o_cycle_count, exp_count);
    chk("load_timeout", o_timeout, 0);
    chk("load_ready", o_cmd_ready, 1);
  endtask

  task automatic do_step(input int delay);
    mark();
    send_cmd(C_STEP);
    wait_dump("step_dumpreq");
    finish_dump(delay);
    tick();
    exp_count++;
    chk("step_enables", en_cyc - b_en, 1);
    chk("step_pulse_len", last_run, 1);
    chk("step_count", o_cycle_count, exp_count);
    chk("step_ready", o_cmd_ready, 1);
  endtask

  // f > 0: program finishes during enable cycle f; f == 0: never finishes (watchdog).
  task automatic do_run(input int f);
    int want;
    mark();
    send_cmd(C_RUN);
    if (f > 0) begin
      repeat (f - 1) tick();
      i_program_finished = 1'b1;
      tick();
      chk("run_stop_en", o_pipeline_enable, 0);
      chk("run_dumpreq", o_dump_req, 1);
      want = f;
    end else begin
      wait_dump("wdog_dumpreq");
      want = MAXR;
    end
    tick();
    exp_count += want;
    chk("run_enables", en_cyc - b_en, want);
    chk("run_burst_len", last_run, want);
    chk("run_count", o_cycle_count, exp_count);
    chk("run_timeout", o_timeout, (f == 0) ? 1 : 0);
  endtask

  task automatic entry_finished(input logic [7:0] code);
    i_program_finished = 1'b1;
    mark();
    send_cmd(code);
    chk("fin_entry_en", o_pipeline_enable, 0);
    chk("fin_entry_dumpreq", o_dump_req, 1);
    i_program_finished = 1'b0;
    finish_dump(2);
    tick();
    chk("fin_entry_enables", en_cyc - b_en, 0);
    chk("fin_entry_count", o_cycle_count, exp_count);
    chk("fin_entry_ready", o_cmd_ready, 1);
  endtask

  task automatic unknown_cmd(input logic [7:0] code);
    mark();
    send_cmd(code);
    tick();
    chk("unk_err", err_cyc - b_err, 1);
    chk("unk_quiet", {o_pipeline_enable, o_dump_req, o_load_mode}, 0);
    chk("unk_ready", o_cmd_ready, 1);
  endtask

  initial begin
    logic [7:0] c;
    i_reset = 1'b1; i_cmd_valid = 1'b0; i_cmd = 8'h00;
    i_load_done = 1'b0; i_program_finished = 1'b0; i_dump_done = 1'b0;
    exp_count = 0;
    repeat (3) tick();
    i_reset = 1'b0;
    tick();
    chk("rst_ready", o_cmd_ready, 1);
    chk("rst_outs", {o_cmd_err, o_load_mode, o_pipeline_flush, o_pipeline_enable, o_dump_req, o_timeout}, 0);
    chk("rst_count", o_cycle_count, 0);

    // Stray completion pulses in IDLE have no effect.
    i_load_done = 1'b1; i_dump_done = 1'b1;
    tick();
    i_load_done = 1'b0; i_dump_done = 1'b0;
    tick();
    chk("stray_done", {o_load_mode, o_dump_req, o_pipeline_flush}, 0);

    do_load(10);
    repeat (3) do_step(5);
    chk("step3_count", o_cycle_count, 3);

    // Run to HALT at enable cycle 20, then HALTED rejects RUN/STEP.
    do_load($urandom_range(2, 12));
    do_run(20);
    finish_dump($urandom_range(1, 6));
    tick();
    chk("halted_ready", o_cmd_ready, 1);
    mark();
    send_cmd(C_RUN);
    tick();
    send_cmd(C_STEP);
    tick();
    chk("halted_err", err_cyc - b_err, 2);
    chk("halted_no_en", en_cyc - b_en, 0);
    chk("halted_quiet", o_dump_req, 0);
    mark();
    send_cmd(C_DUMP);
    chk("halted_dump_req", o_dump_req, 1);
    finish_dump(3);
    tick();
    send_cmd(C_STEP);
    tick();
    chk("still_halted_err", err_cyc - b_err, 1);
    chk("still_halted_no_en", en_cyc - b_en, 0);
    i_program_finished = 1'b0;

    do_load(5);
    entry_finished(C_RUN);
    entry_finished(C_STEP);

    // Watchdog expiry, sticky until the next LOAD.
    do_run(0);
    finish_dump(4);
    tick();
    chk("wdog_ready", o_cmd_ready, 1);
    do_step(2);
    chk("wdog_sticky", o_timeout, 1);
    do_load(3);

    // RUN during DUMP, then a command colliding with dump completion.
    mark();
    send_cmd(C_STEP);
    wait_dump("err_dumpreq");
    send_cmd(C_RUN);
    chk("dump_busy_err", o_cmd_err, 1);
    chk("dump_busy_hold", o_dump_req, 1);
    i_dump_done = 1'b1; i_cmd_valid = 1'b1; i_cmd = C_RUN;
    tick();
    i_dump_done = 1'b0; i_cmd_valid = 1'b0;
    repeat (3) tick();
    exp_count++;
    chk("collide_dump_drop", o_dump_req, 0);
    chk("collide_err", err_cyc - b_err, 2);
    chk("collide_no_run", en_cyc - b_en, 1);
    chk("collide_count", o_cycle_count, exp_count);
    chk("collide_ready", o_cmd_ready, 1);

    unknown_cmd(8'h00);

    for (int it = 0; it < 12; it++) begin
      case ($urandom_range(0, 2))
        0: do_step($urandom_range(1, 6));
        1: begin
          do_run($urandom_range(1, MAXR - 1));
          i_program_finished = 1'b0;
          finish_dump($urandom_range(1, 5));
          tick();
          chk("rand_run_ready", o_cmd_ready, 1);
        end
        default: begin
          do c = 8'($urandom);
          while (c == C_LOAD || c == C_RUN || c == C_STEP || c == C_DUMP);
          unknown_cmd(c);
        end
      endcase
    end

    // Reset in the middle of a run.
    do_load(2);
    send_cmd(C_RUN);
    repeat (6) tick();
    chk("mid_run_en", o_pipeline_enable, 1);
    chk("mid_run_count", o_cycle_count, 7);
    i_reset = 1'b1;
    tick();
    chk("rst_run_outs", {o_pipeline_enable, o_dump_req, o_timeout, o_cmd_err}, 0);
    chk("rst_run_count", o_cycle_count, 0);
    chk("rst_run_ready", o_cmd_ready, 1);
    i_reset = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
